// File: rtl/priority_decoder_driver.sv
// Registered index-to-line decoder: accepts an encoded index and drives the decoded vector for
// HOLD cycles, then idles GAP cycles. Define PRIORITY_DECODER_THERMO_EN for thermometer output.
module priority_decoder_driver #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned HOLD  = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] decoded;
    logic             accept;
    logic             in_range;

    always_comb begin
        decoded = '0;
        for (int i = 0; i < OUT_W; i++) begin
`ifdef PRIORITY_DECODER_THERMO_EN
            decoded[i] = (i <= int'(in));
`else
            decoded[i] = (i == int'(in));
`endif
        end
    end

    assign in_range = (32'(in) < OUT_W);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_d = '0;
                if (accept) begin
                    if (in_range) begin
                        out_d   = decoded;
                        cnt_d   = CNT_W'(HOLD - 1);
                        state_d = S_DRIVE;
                    end else begin
                        // Out-of-range index is consumed but produces no drive.
                        err_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    out_d = '0;
                    if (GAP > 0) begin
                        cnt_d   = CNT_W'(GAP - 1);
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                out_d = '0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                out_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Handshake and pulses are masked while reset is asserted so nothing leaks out of a reset cycle.
    assign in_ready = (state_q == S_IDLE) && !rst;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DRIVE) && (cnt_q == '0) && !rst;
    assign err      = err_q && !rst;
    assign out      = out_q;

endmodule

// File: tb/tb_priority_decoder_driver.sv
// Scoreboard bench for priority_decoder_driver: an 8-wide and a 6-wide instance, each with its
// own driver, time-based reference model and monitor.
module tb_priority_decoder_driver;

    localparam int unsigned HOLD = 4;
    localparam int unsigned GAP  = 1;

    typedef struct {
        int         acc;
        bit         is_err;
        int         idx;
        logic [7:0] val;
    } rec_t;

    logic clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   fin [0:1];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input int p, input int act,
                       input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s inst%0d period %0d: got %0h, expected %0h", name, inst, p, act, exp);
        end
    endtask

    function automatic logic [7:0] expv(input int idx);
`ifdef PRIORITY_DECODER_THERMO_EN
        return 8'((1 << (idx + 1)) - 1);
`else
        return 8'(1 << idx);
`endif
    endfunction

    // Priority encoder: index of the highest set bit, -1 for zero.
    function automatic int penc(input int v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int unsigned OW = (k == 0) ? 8 : 6;

        logic          rst = 1'b1;
        logic          in_valid = 1'b0;
        logic          in_ready;
        logic [2:0]    in = 3'd0;
        logic [OW-1:0] out;
        logic          busy;
        logic          done;
        logic          err;

        priority_decoder_driver #(
            .IN_W (3),
            .OUT_W(OW),
            .HOLD (HOLD),
            .GAP  (GAP)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .in_valid(in_valid),
            .in_ready(in_ready),
            .in      (in),
            .out     (out),
            .busy    (busy),
            .done    (done),
            .err     (err)
        );

        rec_t q[$];
        int   en = 0;
        int   free_edge = 0;
        bit   armed = 1'b0;

        function automatic int rec_end(input rec_t r);
            return r.is_err ? r.acc : r.acc + int'(HOLD + GAP) - 1;
        endfunction

        // Apply inputs for one period, then let the model judge the closing edge.
        task automatic tick(input bit v, input int idx, input bit r, output bit acc);
            in_valid = v;
            in       = 3'(idx);
            rst      = r;
            @(posedge clk);
            en++;
            acc = 1'b0;
            if (r) begin
                q.delete();
                free_edge = en + 1;
                armed     = 1'b1;
            end else if (v && en >= free_edge) begin
                acc = 1'b1;
                if (idx < int'(OW)) begin
                    q.push_back('{en, 1'b0, idx, expv(idx)});
                    free_edge = en + int'(HOLD + GAP) + 1;
                end else begin
                    q.push_back('{en, 1'b1, idx, 8'h00});
                    free_edge = en + 1;
                end
            end
            #1;
        endtask

        task automatic idle(input int n);
            bit a;
            repeat (n) tick(1'b0, 0, 1'b0, a);
        endtask

        // Hold in_valid with a fixed index until the model accepts it.
        task automatic send(input int idx);
            bit a;
            int n = 0;
            do begin
                tick(1'b1, idx, 1'b0, a);
                n++;
            end while (!a && n < 50);
        endtask

        task automatic check_cycle();
            int         p;
            int         d;
            int         e_idx;
            logic [7:0] e_out;
            bit         e_busy, e_rdy, e_done, e_err;
            p      = en;
            e_out  = 8'h00;
            e_idx  = -1;
            e_busy = 1'b0;
            e_rdy  = 1'b1;
            e_done = 1'b0;
            e_err  = 1'b0;
            while (q.size() > 0 && rec_end(q[0]) < p) q.delete(0);
            if (q.size() > 0 && q[0].acc <= p) begin
                if (q[0].is_err) begin
                    e_err = 1'b1;
                end else begin
                    d      = p - q[0].acc;
                    e_busy = 1'b1;
                    e_rdy  = 1'b0;
                    if (d < int'(HOLD)) begin
                        e_out  = q[0].val;
                        e_idx  = q[0].idx;
                        e_done = (d == int'(HOLD) - 1);
                    end
                end
            end
            if (rst) begin
                e_rdy  = 1'b0;
                e_done = 1'b0;
                e_err  = 1'b0;
            end
            chk("out", k, p, int'(out), int'(e_out));
            chk("busy", k, p, int'(busy), int'(e_busy));
            chk("in_ready", k, p, int'(in_ready), int'(e_rdy));
            chk("done", k, p, int'(done), int'(e_done));
            chk("err", k, p, int'(err), int'(e_err));
            if (e_idx >= 0) chk("roundtrip", k, p, penc(int'(out)), e_idx);
        endtask

        initial begin
            while (!fin[k]) begin
                @(negedge clk);
                if (armed && !fin[k]) check_cycle();
            end
        end

        initial begin
            bit a;
            fin[k] = 1'b0;
            repeat (3) tick(1'b0, 0, 1'b1, a);
            idle(2);
            // Single decode of index 5.
            tick(1'b1, 5, 1'b0, a);
            idle(8);
            // Back-to-back sweep with in_valid held.
            for (int i = 0; i < 8; i++) send(i);
            idle(8);
            // Index 7 presented during DRIVE must wait for in_ready.
            send(2);
            send(7);
            idle(8);
            // Out-of-range (narrow instance) followed immediately by a valid index.
            send(6);
            send(3);
            idle(8);
            // Reset on the second DRIVE cycle, then a normal accept.
            send(1);
            tick(1'b0, 0, 1'b0, a);
            tick(1'b0, 0, 1'b1, a);
            idle(1);
            send(4);
            idle(8);
            for (int i = 0; i < 400; i++) begin
                tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     ($urandom_range(0, 59) == 0), a);
            end
            idle(10);
            fin[k] = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        #20;
        wait (fin[0] && fin[1]);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
